// File: rtl/decoder_3to8_pulse.sv
// Registered 3-to-8 decoder: each accepted code becomes a one-hot pulse of PULSE_LEN cycles,
// followed by GAP_LEN idle cycles, with a done strobe on normal completion.
module decoder_3to8_pulse #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [2:0] a,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } state_e;

  localparam logic [7:0] PulseInit = 8'(PULSE_LEN - 1);
  // Only meaningful when GAP_LEN > 0; the gap state is skipped otherwise.
  localparam logic [7:0] GapInit   = 8'(GAP_LEN - 1);
  localparam bit         HasGap    = (GAP_LEN != 0);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] a_q;
  logic [7:0] y_q;
  logic       done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      a_q     <= 3'd0;
      y_q     <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          y_q <= 8'd0;
          if (valid && e) begin
            a_q     <= a;
            cnt_q   <= PulseInit;
            state_q <= StPulse;
            // Load the one-hot now so it is visible for every PULSE cycle.
            y_q     <= 8'd1 << a;
          end
        end
        StPulse: begin
          if (!e) begin
            state_q <= StIdle;
            y_q     <= 8'd0;
            cnt_q   <= 8'd0;
          end else if (cnt_q == 8'd0) begin
            y_q <= 8'd0;
            if (HasGap) begin
              state_q <= StGap;
              cnt_q   <= GapInit;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end else begin
            y_q   <= 8'd1 << a_q;
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StGap: begin
          y_q <= 8'd0;
          if (!e) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
          end else if (cnt_q == 8'd0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          y_q     <= 8'd0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign ready = (state_q == StIdle) && e;
  assign busy  = (state_q != StIdle);
  assign y     = y_q;
  assign done  = done_q;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Directed self-checking bench for decoder_3to8_pulse (default parameters plus a
// PULSE_LEN=1/GAP_LEN=0 instance).
module tb_decoder_3to8_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e, valid, ready, busy, done;
  logic [2:0] a;
  logic [7:0] y;
  logic       b_e, b_valid, b_ready, b_busy, b_done;
  logic [2:0] b_a;
  logic [7:0] b_y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  decoder_3to8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (e),
    .a     (a),
    .valid (valid),
    .ready (ready),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  decoder_3to8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (b_e),
    .a     (b_a),
    .valid (b_valid),
    .ready (b_ready),
    .y     (b_y),
    .busy  (b_busy),
    .done  (b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int acc_cyc, prev_cyc;
    rst_n = 1'b0; e = 1'b0; valid = 1'b0; a = 3'd0;
    b_e = 1'b0; b_valid = 1'b0; b_a = 3'd0;
    #12;
    check("reset_y", 32'(y), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready_e0", 32'(ready), 32'd0);
    step();
    rst_n = 1'b1;
    e     = 1'b1;
    #1;
    check("ready_after_reset", 32'(ready), 32'd1);

    // Single code 5: four cycles of 8'h20, one gap cycle, then done.
    a = 3'b101; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("single_pulse_y", 32'(y), 32'h20);
      check("single_pulse_busy", 32'(busy), 32'd1);
      check("single_pulse_ready", 32'(ready), 32'd0);
      step();
    end
    check("single_gap_y", 32'(y), 32'h00);
    check("single_gap_done", 32'(done), 32'd0);
    check("single_gap_busy", 32'(busy), 32'd1);
    step();
    check("single_done", 32'(done), 32'd1);
    check("single_done_ready", 32'(ready), 32'd1);
    check("single_done_y", 32'(y), 32'h00);
    step();
    check("single_done_clear", 32'(done), 32'd0);

    // Back-to-back sweep 0..7 with valid held high.
    valid    = 1'b1;
    prev_cyc = 0;
    for (int code = 0; code < 8; code++) begin
      a = 3'(code);
      check("sweep_ready", 32'(ready), 32'd1);
      acc_cyc = cyc;
      if (code > 0) check("sweep_spacing", 32'(acc_cyc - prev_cyc), 32'd6);
      prev_cyc = acc_cyc;
      step();
      for (int j = 0; j < 4; j++) begin
        check("sweep_y", 32'(y), 32'(8'd1 << code));
        check("sweep_onehot0", 32'($onehot0(y)), 32'd1);
        step();
      end
      check("sweep_gap_y", 32'(y), 32'h00);
      step();
      check("sweep_done", 32'(done), 32'd1);
    end
    valid = 1'b0;
    step();
    check("sweep_end_busy", 32'(busy), 32'd0);

    // Abort: drop e two cycles into a pulse of code 2.
    a = 3'b010; valid = 1'b1;
    step();
    valid = 1'b0;
    check("abort_y_pre", 32'(y), 32'h04);
    step();
    check("abort_y_pre2", 32'(y), 32'h04);
    e = 1'b0;
    #1;
    check("abort_ready_e0", 32'(ready), 32'd0);
    step();
    check("abort_y", 32'(y), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int j = 0; j < 4; j++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_ready_hold", 32'(ready), 32'd0);
    end

    // valid while e is low is ignored; raising e with valid accepts the same cycle.
    a = 3'b001; valid = 1'b1;
    step();
    check("e0_no_accept", 32'(busy), 32'd0);
    e = 1'b1;
    #1;
    check("e_rise_ready", 32'(ready), 32'd1);
    step();
    valid = 1'b0;
    check("e_rise_y", 32'(y), 32'h02);
    repeat (5) step();
    check("e_rise_done", 32'(done), 32'd1);
    step();

    // Asynchronous reset in the middle of a code-7 pulse.
    a = 3'b111; valid = 1'b1;
    step();
    valid = 1'b0;
    check("rst_pre_y", 32'(y), 32'h80);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(y), 32'h00);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    step();

    // Code changes and valid pulses during an active pulse are ignored.
    a = 3'b011; valid = 1'b1;
    step();
    a = 3'b110;
    check("hold_y0", 32'(y), 32'h08);
    check("hold_ready", 32'(ready), 32'd0);
    step();
    valid = 1'b0;
    a = 3'b100;
    for (int j = 0; j < 3; j++) begin
      check("hold_y", 32'(y), 32'h08);
      check("hold_ready_busy", 32'(ready), 32'd0);
      step();
    end
    check("hold_gap_ready", 32'(ready), 32'd0);
    step();
    check("hold_done", 32'(done), 32'd1);
    check("hold_done_ready", 32'(ready), 32'd1);
    step();
    check("hold_no_accept", 32'(busy), 32'd0);
    check("hold_no_accept_y", 32'(y), 32'h00);

    // PULSE_LEN=1, GAP_LEN=0 instance: codes 0 then 7 with valid held.
    b_e = 1'b1; b_a = 3'b000; b_valid = 1'b1;
    #1;
    check("b_ready", 32'(b_ready), 32'd1);
    step();
    b_a = 3'b111;
    check("b_y0", 32'(b_y), 32'h01);
    check("b_busy0", 32'(b_busy), 32'd1);
    step();
    check("b_idle_y", 32'(b_y), 32'h00);
    check("b_idle_done", 32'(b_done), 32'd1);
    check("b_idle_ready", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    check("b_y7", 32'(b_y), 32'h80);
    check("b_y7_done", 32'(b_done), 32'd0);
    step();
    check("b_end_y", 32'(b_y), 32'h00);
    check("b_end_done", 32'(b_done), 32'd1);
    step();
    check("b_end_done_clear", 32'(b_done), 32'd0);
    check("b_end_busy", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
